// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and an iterative unsigned multiply.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; operands and selects sampled on accept
//   a, b                  WIDTH-bit operands
//   ALUSel                000 add/sub, 001 OR, 010 AND, 011 XOR, 100 SLL, 101 SRL/SRA, 110 cmp, 111 MUL
//   AddSel, ArithSel      subtract select, arithmetic right shift select
//   CompSel, sign         compare relation, signed compare / signed overflow
//   out_valid / out_ready result handshake; z and flags hold until consumed
//   z, overflow, zero, cflag  result and status flags
module alu_pipe #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUSel,
  input  logic             AddSel,
  input  logic             ArithSel,
  input  logic [2:0]       CompSel,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             overflow,
  output logic             zero,
  output logic             cflag
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               ov_q, ov_d, zero_q, zero_d, cf_q, cf_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic accept, retire, mul_last;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;
  assign mul_last = (state_q == MUL) && (cnt_q == SHW'(WIDTH - 1));

  // Single-cycle datapath
  logic [WIDTH-1:0]        b_eff, sll_z, srl_z, sra_z;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH:0]          sum;
  logic [SHW-1:0]          shamt;
  logic                    lt, eq, cmp_res;

  assign b_eff = AddSel ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(AddSel);
  assign shamt = b[SHW-1:0];
  assign a_s   = $signed(a);
  assign sll_z = a << shamt;
  assign srl_z = a >> shamt;
  // Kept in its own assignment so the shift stays signed
  assign sra_z = a_s >>> shamt;
  assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);
  assign eq    = (a == b);

  always_comb begin
    cmp_res = 1'b0;
    if (CompSel[2]) begin
      cmp_res = CompSel[0] ? !eq : eq;
    end else begin
      case (CompSel[1:0])
        2'b00:   cmp_res = !lt && !eq;
        2'b01:   cmp_res = !lt;
        2'b10:   cmp_res = lt;
        default: cmp_res = lt || eq;
      endcase
    end
  end

  logic [WIDTH-1:0] res_z;
  logic             res_ov, res_cf;

  always_comb begin
    res_z  = '0;
    res_ov = 1'b0;
    res_cf = 1'b0;
    case (ALUSel)
      3'b000: begin
        res_z  = sum[WIDTH-1:0];
        // Subtract reports borrow, i.e. the inverted carry
        res_cf = AddSel ? !sum[WIDTH] : sum[WIDTH];
        res_ov = sign && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001:  res_z = a | b;
      3'b010:  res_z = a & b;
      3'b011:  res_z = a ^ b;
      3'b100:  res_z = sll_z;
      3'b101:  res_z = ArithSel ? sra_z : srl_z;
      3'b110:  res_z = {{(WIDTH - 1){1'b0}}, cmp_res};
      default: res_z = '0;
    endcase
  end

  // Shift-add step: acc = {partial high, remaining multiplier bits}
  logic [WIDTH:0]     mul_hi;
  logic [2*WIDTH-1:0] acc_step;

  assign mul_hi   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {mul_hi, acc_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (ALUSel == 3'b111)) state_d = MUL;
      default: if (mul_last) state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    out_valid_d = out_valid_q;
    z_d         = z_q;
    ov_d        = ov_q;
    zero_d      = zero_q;
    cf_d        = cf_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    if (retire) out_valid_d = 1'b0;
    if (accept) begin
      if (ALUSel == 3'b111) begin
        acc_d   = {{WIDTH{1'b0}}, b};
        mcand_d = a;
        cnt_d   = '0;
      end else begin
        z_d         = res_z;
        ov_d        = res_ov;
        cf_d        = res_cf;
        zero_d      = (res_z == '0);
        out_valid_d = 1'b1;
      end
    end
    if (state_q == MUL) begin
      acc_d = acc_step;
      cnt_d = cnt_q + SHW'(1);
      if (mul_last) begin
        z_d         = acc_step[WIDTH-1:0];
        ov_d        = 1'b0;
        cf_d        = (acc_step[2*WIDTH-1:WIDTH] != '0);
        zero_d      = (acc_step[WIDTH-1:0] == '0);
        out_valid_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ov_q        <= 1'b0;
      zero_q      <= 1'b0;
      cf_q        <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      ov_q        <= ov_d;
      zero_q      <= zero_d;
      cf_q        <= cf_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign overflow  = ov_q;
  assign zero      = zero_q;
  assign cflag     = cf_q;

endmodule
